// File: rtl/lb_frame_sequencer.sv
// lb_frame_sequencer
//   Frame loop around collide_stream_fsm. On the first start after reset it
//   fills the lattice with rest equilibrium and places the ship. Every frame
//   it rewrites the boundary cells, then runs collide, stream, move_trace and
//   speed_color, and counts frames.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start, stop         one-cycle control pulses (stop honoured at frame end)
//   frame_limit         frames per run, 0 = free-run
//   u0                  signed 2.25 inflow speed, latched on accepted start
//   start_init / init_finish, write_address_init, bnd_ux, bnd_uy
//                       cell-write handshake and the velocity to write
//   init_ship           high while the ship-placement move_trace is requested
//   start_* / *_finish  four-phase handshakes to collide_stream_fsm
//   busy, frame_count, filled   status
module lb_frame_sequencer #(
  parameter int NX     = 136,
  parameter int NY     = 72,
  parameter int JET_LO = 31,
  parameter int JET_HI = 39,
  parameter int AW     = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [15:0]          frame_limit,
  input  logic signed [26:0]   u0,
  output logic                 start_init,
  input  logic                 init_finish,
  output logic [AW-1:0]        write_address_init,
  output logic signed [26:0]   bnd_ux,
  output logic signed [26:0]   bnd_uy,
  output logic                 init_ship,
  output logic                 start_collide,
  input  logic                 collide_finish,
  output logic                 start_stream,
  input  logic                 stream_finish,
  output logic                 start_move_trace,
  input  logic                 move_trace_finish,
  output logic                 start_speed_color,
  input  logic                 speed_color_finish,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic                 filled
);

  localparam int DATA_W = 27;
  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NX*NY-1);
  localparam logic [AW-1:0] BOT_ROW   = AW'(NX*(NY-1));
  localparam logic [AW-1:0] STEP      = AW'(NX);
  localparam logic [AW-1:0] X_LAST    = AW'(NX-1);
  localparam logic [AW-1:0] Y_LAST    = AW'(NY-2);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_SHIP, S_BND, S_COLLIDE, S_STREAM, S_TRACE, S_COLOR, S_NEXT
  } state_t;

  // LOAD: first cell after start (u0 is only latched by then)
  // SETUP: address/data already on the outputs, request rises next edge
  typedef enum logic [1:0] {PH_LOAD, PH_SETUP, PH_REQ, PH_WAIT} ph_t;

  function automatic logic signed [DATA_W-1:0] half_speed(input logic signed [DATA_W-1:0] u);
    return u >>> 1;
  endfunction

  function automatic logic signed [DATA_W-1:0] neg_wrap(input logic signed [DATA_W-1:0] u);
    return -u;
  endfunction

  function automatic logic signed [DATA_W-1:0] left_ux(input logic [AW-1:0] y,
                                                       input logic signed [DATA_W-1:0] u);
    if (int'(y) >= JET_LO && int'(y) <= JET_HI) return u;
    return '0;
  endfunction

  // Shear inflow below the jet drifts up, above the jet drifts down.
  function automatic logic signed [DATA_W-1:0] left_uy(input logic [AW-1:0] y,
                                                       input logic signed [DATA_W-1:0] u);
    if (int'(y) >= JET_LO && int'(y) <= JET_HI) return '0;
    if (int'(y) < JET_LO) return half_speed(u);
    return neg_wrap(half_speed(u));
  endfunction

  state_t                    state_q, state_d;
  ph_t                       ph_q, ph_d;
  logic                      req_q, req_d;
  logic [AW-1:0]             x_q, x_d, y_q, y_d, row_q, row_d, addr_q, addr_d;
  logic                      side_q, side_d, wall_q, wall_d;
  logic signed [DATA_W-1:0]  ux_q, ux_d, uy_q, uy_d;
  logic [15:0]               fc_q, fc_d;
  logic                      filled_q, filled_d, stop_q, stop_d;
  logic signed [DATA_W-1:0]  u0_l;
  logic                      fin, hs_done, load_bnd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ph_q     <= PH_LOAD;
      req_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      side_q   <= 1'b0;
      wall_q   <= 1'b0;
      ux_q     <= '0;
      uy_q     <= '0;
      fc_q     <= '0;
      filled_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      req_q    <= req_d;
      x_q      <= x_d;
      y_q      <= y_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      side_q   <= side_d;
      wall_q   <= wall_d;
      ux_q     <= ux_d;
      uy_q     <= uy_d;
      fc_q     <= fc_d;
      filled_q <= filled_d;
      stop_q   <= stop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) u0_l <= u0;
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    req_d    = req_q;
    x_d      = x_q;
    y_d      = y_q;
    row_d    = row_q;
    addr_d   = addr_q;
    side_d   = side_q;
    wall_d   = wall_q;
    ux_d     = ux_q;
    uy_d     = uy_q;
    fc_d     = fc_q;
    filled_d = filled_q;
    stop_d   = stop_q;
    hs_done  = 1'b0;
    load_bnd = 1'b0;

    case (state_q)
      S_FILL, S_BND:   fin = init_finish;
      S_SHIP, S_TRACE: fin = move_trace_finish;
      S_COLLIDE:       fin = collide_finish;
      S_STREAM:        fin = stream_finish;
      S_COLOR:         fin = speed_color_finish;
      default:         fin = 1'b0;
    endcase

    if (stop && state_q != S_IDLE) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stop_d  = stop;
          fc_d    = '0;
          req_d   = 1'b0;
          ph_d    = PH_LOAD;
          state_d = filled_q ? S_BND : S_FILL;
        end
      end
      S_NEXT: begin
        fc_d = fc_q + 16'd1;
        if (stop_q || (frame_limit != 16'd0 && fc_d == frame_limit)) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_BND;
          ph_d     = PH_SETUP;
          load_bnd = 1'b1;
        end
      end
      default: begin
        case (ph_q)
          PH_LOAD: begin
            ph_d = PH_SETUP;
            if (state_q == S_FILL) begin
              addr_d = '0;
              ux_d   = '0;
              uy_d   = '0;
            end else begin
              load_bnd = 1'b1;
            end
          end
          PH_SETUP: begin
            req_d = 1'b1;
            ph_d  = PH_REQ;
          end
          PH_REQ: begin
            if (fin) begin
              req_d = 1'b0;
              ph_d  = PH_WAIT;
            end
          end
          default: begin
            if (!fin) hs_done = 1'b1;
          end
        endcase
      end
    endcase

    if (hs_done) begin
      ph_d = PH_SETUP;
      case (state_q)
        S_FILL: begin
          if (addr_q == LAST_ADDR) begin
            filled_d = 1'b1;
            state_d  = S_SHIP;
          end else begin
            addr_d = addr_q + ONE;
          end
        end
        S_SHIP: begin
          state_d  = S_BND;
          load_bnd = 1'b1;
        end
        S_BND: begin
          if (wall_q) begin
            // Top cell then bottom cell of each column; bottom row base is a constant.
            if (!side_q) begin
              side_d = 1'b1;
              addr_d = x_q + BOT_ROW;
            end else if (x_q == X_LAST) begin
              wall_d = 1'b0;
              side_d = 1'b0;
              y_d    = ONE;
              row_d  = STEP;
              addr_d = STEP;
              ux_d   = left_ux(ONE, u0_l);
              uy_d   = left_uy(ONE, u0_l);
            end else begin
              side_d = 1'b0;
              x_d    = x_q + ONE;
              addr_d = x_q + ONE;
            end
          end else begin
            // Left cell then right cell of each interior row; row base steps by NX.
            if (!side_q) begin
              side_d = 1'b1;
              addr_d = row_q + X_LAST;
              ux_d   = u0_l;
              uy_d   = '0;
            end else if (y_q == Y_LAST) begin
              state_d = S_COLLIDE;
            end else begin
              side_d = 1'b0;
              y_d    = y_q + ONE;
              row_d  = row_q + STEP;
              addr_d = row_q + STEP;
              ux_d   = left_ux(y_q + ONE, u0_l);
              uy_d   = left_uy(y_q + ONE, u0_l);
            end
          end
        end
        S_COLLIDE: state_d = S_STREAM;
        S_STREAM:  state_d = S_TRACE;
        S_TRACE:   state_d = S_COLOR;
        S_COLOR:   state_d = S_NEXT;
        default:   state_d = state_q;
      endcase
    end

    if (load_bnd) begin
      wall_d = 1'b1;
      side_d = 1'b0;
      x_d    = '0;
      addr_d = '0;
      ux_d   = u0_l;
      uy_d   = '0;
    end
  end

  assign start_init         = req_q && (state_q == S_FILL || state_q == S_BND);
  assign start_collide      = req_q && (state_q == S_COLLIDE);
  assign start_stream       = req_q && (state_q == S_STREAM);
  assign start_move_trace   = req_q && (state_q == S_SHIP || state_q == S_TRACE);
  assign start_speed_color  = req_q && (state_q == S_COLOR);
  assign init_ship          = (state_q == S_SHIP) && (ph_q != PH_WAIT);
  assign busy               = (state_q != S_IDLE);
  assign write_address_init = addr_q;
  assign bnd_ux             = ux_q;
  assign bnd_uy             = uy_q;
  assign frame_count        = fc_q;
  assign filled             = filled_q;

endmodule

// File: doc/lb_frame_sequencer.md
# lb_frame_sequencer

Hardware replacement for the software frame loop around `collide_stream_fsm`. It fills the lattice with rest equilibrium and then places the ship. Each frame it rewrites the boundary cells (top/bottom walls, left-edge jet/shear inflow, right outflow), then runs collide → stream → move_trace → speed_color. It counts frames. It sits between the HPS/control registers and `collide_stream_fsm`; an external combinational equilibrium unit turns `bnd_ux`/`bnd_uy` (rho fixed at 1.0) into the nine `n*_init_data` words.

## Interface
Parameters:
- NX, 136, lattice width
- NY, 72, lattice height
- JET_LO, 31, first left-edge row driven with ux=u0
- JET_HI, 39, last left-edge row driven with ux=u0
- AW, 14, cell address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse; begin/resume running (ignored when busy)
- stop  in  1  one-cycle pulse; latched, honoured at next frame boundary
- frame_limit  in  16  frames per run; 0 = free-run
- u0  in  27  signed 2.25 inflow speed, sampled on accepted start
- start_init / init_finish  out/in  1  cell-write handshake
- write_address_init  out  AW  cell address x + NX*y
- bnd_ux, bnd_uy  out  27  signed velocity for current write
- init_ship  out  1  high during ship placement
- start_collide / collide_finish  out/in  1
- start_stream / stream_finish  out/in  1
- start_move_trace / move_trace_finish  out/in  1
- start_speed_color / speed_color_finish  out/in  1
- busy  out  1  high in any state but IDLE
- frame_count  out  16  frames completed in current run
- filled  out  1  lattice initialised since reset

## Operation
- States: IDLE, FILL, SHIP, BND, COLLIDE, STREAM, TRACE, COLOR, NEXT.
- IDLE + start: latch u0, clear frame_count and the stop latch. Go to FILL if filled=0, else BND.
- FILL: writes every address 0..NX*NY-1 in order with ux=uy=0. Sets filled, then goes to SHIP.
- SHIP: init_ship=1 and runs one move_trace handshake. init_ship drops with start_move_trace. Then goes to BND.
- BND: 2*NX + 2*(NY-2) writes, in this order:
  - for x=0..NX-1: (x,0) then (x,NY-1), both ux=u0, uy=0;
  - for y=1..NY-2, left cell (0,y):
    - JET_LO≤y≤JET_HI: ux=u0, uy=0;
    - y<JET_LO: ux=0, uy=u0>>>1;
    - y>JET_HI: ux=0, uy=−(u0>>>1);
  - then right cell (NX-1,y): ux=u0, uy=0.
- COLLIDE, STREAM, TRACE, COLOR: one handshake each, in that order.
- NEXT: frame_count+1 (wraps at 2^16). Go to IDLE if the stop latch is set or (frame_limit≠0 and the new count = frame_limit); else go to BND.
- Address is generated incrementally: row-base register advances by NX; no multiplier. u0>>>1 is an arithmetic shift; −(u0>>>1) is two's complement, 27-bit wrap.
- stop in IDLE is ignored. stop during FILL/SHIP is latched and takes effect after the first frame's NEXT.

## Timing
- Handshake (all five), four-phase:
  - write_address_init/bnd_ux/bnd_uy are valid ≥1 cycle before start_* rises, and stay stable until start_* falls;
  - start_* rises, holds until finish=1, falls on the cycle after finish is sampled high;
  - the next start_* may not rise until the finish just used is sampled low.
- At most one start_* is high at any time.
- Accepted start → first start_* high: 2 cycles.
- Reset (async assert, any state) takes effect immediately:
  - all outputs are 0: all start_*, init_ship, busy, frame_count, write_address_init, bnd_ux/uy, filled;
  - state=IDLE;
  - an in-flight handshake is abandoned.
- After reset deassert, state holds IDLE until start.
- start and stop in the same cycle while IDLE: start accepted, stop latched, run ends after 1 frame.

## Test plan
- NX=8, NY=6, JET_LO=2, JET_HI=3, responder acks after 3 cycles; start, u0=2684354, frame_limit=1 → 48 FILL writes at addresses 0..47, all ux=uy=0; one SHIP move_trace with init_ship=1; 24 BND writes; collide/stream/trace/color once each; then IDLE with frame_count=1 and filled=1.
- Same config, check BND sequence → addresses 0,40,1,41,…,7,47, then 8,15,16,23,24,31,32,39. uy at address 8 = 1342177; address 16 ux=2684354, uy=0; address 32 uy=−1342177.
- Second start with filled=1 and frame_limit=3 → no FILL/SHIP; 3 frames; frame_count=3.
- frame_limit=0, stop pulsed mid-STREAM of frame 2 → frame 2 completes all four phases, then IDLE with frame_count=2.
- Responder holds finish high 5 extra cycles → next start_* stays low until finish is low; never two start_* high together.
- rst low during a BND write with start_init high → all outputs 0 on the next edge. A subsequent start re-runs FILL.
